student_pc: RTL and testbench
=============================

# student_pc

16-bit program counter register for the Hack CPU datapath. It holds the instruction address presented to instruction memory. It also sits directly downstream of the gate-level logic (and16, mux16, inc16), which forms its next-value path. Each cycle it clears, loads a jump target, increments, or holds, with a fixed priority.

## Interface
- `WIDTH`, default 16: counter and data width in bits.
- `RESET_VALUE`, default 16'h0000: value forced by `rst`.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `clr`  in  1: synchronous clear to 0; Hack "reset" pin semantics.
- `load`  in  1: synchronous load of `in`.
- `inc`  in  1: synchronous increment.
- `in`  in  WIDTH: jump target.
- `out`  out  WIDTH: current PC, registered.
- `wrap`  out  1: registered; 1 for exactly one cycle after an increment from all-ones to 0.

## Operation
- Next-value priority, evaluated every cycle:
  - `clr` → 0
  - else `load` → `in`
  - else `inc` → `out`+1 mod 2^WIDTH
  - else hold
- Lower-priority controls asserted together with a higher one are ignored, with no side effect.
- Increment is unsigned, modulo 2^WIDTH. All-ones + 1 → 0 and sets `wrap`.
- `wrap` is cleared on every edge where the selected action is not a wrapping increment, including `clr`, `load`, and hold.
- `load` of all-ones does not set `wrap`.
- `rst` asserted forces `out`=RESET_VALUE and `wrap`=0 immediately, independent of `clk`. Both are held while `rst`=1, and all controls are ignored.
- `rst` mid-sequence: any in-flight value is discarded. There is no pending action after release.
- `clr` differs from `rst`: it is synchronous, always targets 0 (not RESET_VALUE), and acts only on a clock edge.

## Timing
- Reset values: `out`=RESET_VALUE and `wrap`=0 while `rst`=1.
- Latency: controls and `in` are sampled on rising `clk`. The result is visible on `out` one cycle later (single-register stage). `out` is never combinationally dependent on inputs.
- First active edge: the first rising edge with `rst`=0 evaluates controls normally. `rst` deasserted coincident with an edge: that edge is ignored. The first action occurs on the next edge.
- Throughput: one action per cycle. Consecutive `inc` cycles yield a strictly sequential address stream with no bubbles.
- `load` followed by `inc` on the next cycle: `in`, then `in`+1.
- Setup: `in`, `clr`, `load`, and `inc` must be stable before the rising edge. There is no handshake; the controller owns the control lines.

## Structure
- Shared package `hack_pkg` holds:
  - `WORD_W`=16
  - `PC_RESET`=16'h0000
  - A 2-bit next-PC select enum: `SEL_HOLD`, `SEL_INC`, `SEL_LOAD`, `SEL_CLR`. This enum is reused by the CPU control decoder.
- Next-value path:
  - Priority select is built from the team's gate library: student_not, student_and, student_or, student_mux16.
  - The incrementer is student_inc16.
  - No built-in `+` or `?:` for the select path.
- One sub-module, `student_register16`: WIDTH flip-flops with async active-high `rst`, per-register reset value, and load enable. `student_pc` instantiates it for `out`. The `wrap` flop is a separate 1-bit register.
- `wrap` is derived from the incrementer carry-out gated with `SEL_INC`.

## Test plan
- Reset and hold:
  - `rst`=1 with `clk` stopped → `out`=0000, `wrap`=0 immediately.
  - Release, then 3 edges with no controls → `out` stays 0000.
- Increment:
  - From reset, `inc`=1 for 5 edges → `out` = 0001, 0002, 0003, 0004, 0005 on successive cycles.
- Priority:
  - `in`=1234, `load`=`inc`=1 → `out`=1234.
  - Next edge, `clr`=`load`=`inc`=1 → `out`=0000.
  - Next edge, `inc` only → `out`=0001.
- Wrap:
  - `load` FFFF → `out`=FFFF, `wrap`=0.
  - Next edge, `inc` → `out`=0000, `wrap`=1.
  - Following edge, hold → `wrap`=0.
- Asynchronous reset mid-run:
  - Counting at 0042, assert `rst` between edges → `out`=0000 before the next edge.
  - Deassert coincident with an edge while `inc`=1 → that edge ignored. `out`=0001 one edge later.
- Parameter override:
  - RESET_VALUE=16'h0100 → after `rst`, `out`=0100.
  - Then `clr` → `out`=0000, confirming `clr` ignores RESET_VALUE.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack CPU datapath definitions: word width, PC reset value and the
// next-PC select encoding that the control decoder also uses.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] PC_RESET = 16'h0000;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_INC  = 2'b01,
    SEL_LOAD = 2'b10,
    SEL_CLR  = 2'b11
  } next_sel_e;

endpackage

// File: rtl/student_gates.sv
// Gate library used by the datapath: inverter, 2-input and/or, word-wide
// 2:1 mux and a ripple incrementer with carry-out.
module student_not (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module student_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module student_or (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module student_mux16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  // sel=0 passes a, sel=1 passes b, built from masking rather than ?:
  assign y = (a & {WIDTH{~sel}}) | (b & {WIDTH{sel}});
endmodule

module student_inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_half_add
    assign y[i]   = a[i] ^ c[i];
    assign c[i+1] = a[i] & c[i];
  end

  assign carry = c[WIDTH];
endmodule

// File: rtl/student_register16.sv
// WIDTH-bit register with asynchronous active-high reset to a configurable
// value and a synchronous load enable.
module student_register16 #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/student_pc.sv
// Hack program counter: clear > load > increment > hold, one action per edge,
// with a one-cycle wrap flag when an increment rolls over from all-ones.
module student_pc
  import hack_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  logic             n_load;
  logic             inc_only;
  logic             sel_hi;
  logic             sel_lo;
  logic             en;
  logic             carry;
  logic             is_inc;
  logic             wrap_next;
  next_sel_e        sel;
  logic [WIDTH-1:0] zero;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] low_val;
  logic [WIDTH-1:0] high_val;
  logic [WIDTH-1:0] next_val;

  assign zero = '0;

  // Priority encode the controls straight into the select code bits.
  student_not u_n_load   (.a(load), .y(n_load));
  student_and u_inc_only (.a(inc),  .b(n_load),   .y(inc_only));
  student_or  u_sel_hi   (.a(clr),  .b(load),     .y(sel_hi));
  student_or  u_sel_lo   (.a(clr),  .b(inc_only), .y(sel_lo));
  student_or  u_en       (.a(sel_hi), .b(sel_lo), .y(en));

  assign sel    = next_sel_e'({sel_hi, sel_lo});
  assign is_inc = (sel == SEL_INC);

  student_inc16 #(.WIDTH(WIDTH)) u_inc (
    .a     (out),
    .y     (inc_val),
    .carry (carry)
  );

  // sel_lo picks within each pair (hold/inc, load/clr); sel_hi picks the pair.
  student_mux16 #(.WIDTH(WIDTH)) u_mux_low (
    .a   (out),
    .b   (inc_val),
    .sel (sel_lo),
    .y   (low_val)
  );

  student_mux16 #(.WIDTH(WIDTH)) u_mux_high (
    .a   (in),
    .b   (zero),
    .sel (sel_lo),
    .y   (high_val)
  );

  student_mux16 #(.WIDTH(WIDTH)) u_mux_out (
    .a   (low_val),
    .b   (high_val),
    .sel (sel_hi),
    .y   (next_val)
  );

  student_and u_wrap_gate (.a(carry), .b(is_inc), .y(wrap_next));

  student_register16 #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (next_val),
    .q   (out)
  );

  // Reloaded every edge so any non-wrapping action clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_student_pc.sv
// Self-checking bench for student_pc: default instance plus a RESET_VALUE
// override instance, compared against a behavioural model every cycle.
module tb_student_pc;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        wrap_a;
  logic        wrap_b;
  logic        check_en = 1'b0;

  logic [15:0] exp_out [2];
  logic        exp_wrap [2];
  logic [15:0] reset_val [2];

  int n_checks = 0;
  int n_fail = 0;

  student_pc u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .inc  (inc),
    .in   (din),
    .out  (out_a),
    .wrap (wrap_a)
  );

  student_pc #(.WIDTH(16), .RESET_VALUE(16'h0100)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .inc  (inc),
    .in   (din),
    .out  (out_b),
    .wrap (wrap_b)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act_o, input logic act_w,
                             input logic [15:0] req_o, input logic req_w);
    n_checks++;
    if (act_o !== req_o || act_w !== req_w) begin
      n_fail++;
      $display("[TB] FAIL %s: got out=%h wrap=%b, expected out=%h wrap=%b",
               name, act_o, act_w, req_o, req_w);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      exp_out[i]  = reset_val[i];
      exp_wrap[i] = 1'b0;
    end
  endtask

  task automatic modelEdge(input logic c, input logic l, input logic n, input logic [15:0] d);
    for (int i = 0; i < 2; i++) begin
      exp_wrap[i] = !c && !l && n && (exp_out[i] == 16'hFFFF);
      if (c)      exp_out[i] = 16'h0000;
      else if (l) exp_out[i] = d;
      else if (n) exp_out[i] = exp_out[i] + 16'h0001;
    end
  endtask

  // Called just after a falling edge: drive controls, advance one rising edge.
  task automatic applyStimulus(input logic c, input logic l, input logic n, input logic [15:0] d);
    clr  = c;
    load = l;
    inc  = n;
    din  = d;
    @(posedge clk);
    if (!rst) modelEdge(c, l, n, d);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cycle_a", out_a, wrap_a, exp_out[0], exp_wrap[0]);
      checkOutput("cycle_b", out_b, wrap_b, exp_out[1], exp_wrap[1]);
    end
  end

  initial begin
    reset_val[0] = 16'h0000;
    reset_val[1] = 16'h0100;
    exp_out[0] = 16'h0000;
    exp_out[1] = 16'h0000;
    exp_wrap[0] = 1'b0;
    exp_wrap[1] = 1'b0;

    // Reset with the clock stopped must take effect immediately.
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_a", out_a, wrap_a, 16'h0000, 1'b0);
    checkOutput("reset_b", out_b, wrap_b, 16'h0100, 1'b0);

    clk_en = 1'b1;
    inc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset_held_inc_ignored", out_a, wrap_a, 16'h0000, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("hold_3", out_a, wrap_a, 16'h0000, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkOutput("inc_seq", out_a, wrap_a, 16'(i), 1'b0);
    end
    checkOutput("model_inc5_b", exp_out[1], exp_wrap[1], 16'h0105, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    checkOutput("load_over_inc", out_a, wrap_a, 16'h1234, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h5678);
    checkOutput("clr_over_all", out_a, wrap_a, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5678);
    checkOutput("inc_after_clr", out_a, wrap_a, 16'h0001, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    checkOutput("load_ffff", out_a, wrap_a, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("wrap_set", out_a, wrap_a, 16'h0000, 1'b1);
    checkOutput("model_wrap", exp_out[0], exp_wrap[0], 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap_cleared", out_a, wrap_a, 16'h0000, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0007);
    checkOutput("load_from_ffff_no_wrap", out_a, wrap_a, 16'h0007, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("count_0042", out_a, wrap_a, 16'h0042, 1'b0);

    // Asynchronous reset between edges, released just after an edge with inc held.
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset_a", out_a, wrap_a, 16'h0000, 1'b0);
    checkOutput("async_reset_b", out_b, wrap_b, 16'h0100, 1'b0);
    inc = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("release_edge_ignored", out_a, wrap_a, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("first_inc_a", out_a, wrap_a, 16'h0001, 1'b0);
    checkOutput("first_inc_b", out_b, wrap_b, 16'h0101, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("clr_ignores_reset_value", out_b, wrap_b, 16'h0000, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
